ultrasonic_scheduler: RTL and testbench

ULTRASONIC_SCHEDULER -- requirements
Module: ultrasonic_scheduler

---
 rtl/ultrasonic_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_ultrasonic_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler for N_CH ultrasonic rangers: triggers one sensor at a time,
// times its echo pulse and converts the width to millimetres.
module ultrasonic_scheduler #(
  parameter int unsigned N_CH           = 3,
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned GAP_CYCLES     = 100000,
  parameter int unsigned OBST_MM        = 70
) (
  input  logic                 clk_50M,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_CH-1:0]      ch_mask,
  input  logic [N_CH-1:0]      echo_rx,
  output logic [N_CH-1:0]      trig,
  output logic [16*N_CH-1:0]   distance_out,
  output logic [N_CH-1:0]      op,
  output logic [N_CH-1:0]      timeout,
  output logic                 meas_done,
  output logic [1:0]           meas_ch,
  output logic                 busy
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [CH_W:0] N_CH_L       = (CH_W+1)'(N_CH);
  localparam logic [31:0]   TRIG_LAST    = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   GAP_LAST     = 32'(GAP_CYCLES - 1);
  localparam logic [15:0]   OBST_TH      = 16'(OBST_MM);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StTrig,
    StWaitEcho,
    StMeasure,
    StCalc,
    StGap
  } state_e;

  state_e            state_q;
  logic [N_CH-1:0]   echo_meta_q;
  logic [N_CH-1:0]   echo_sync_q;
  logic              echo_prev_q;
  logic [31:0]       cnt_q;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   last_q;
  logic              first_q;
  logic              phase_q;
  logic [15:0]       dist_new_q;
  logic [15:0]       dist_q [N_CH];
  logic [N_CH-1:0]   trig_q;
  logic [N_CH-1:0]   op_q;
  logic [N_CH-1:0]   to_q;
  logic              meas_done_q;
  logic [1:0]        meas_ch_q;

  logic              echo_cur;
  logic              sel_found;
  logic [CH_W-1:0]   sel_ch;
  logic [CH_W:0]     sel_base;
  logic [CH_W:0]     sel_idx;
  logic [15:0]       dist_calc;

  assign echo_cur = echo_sync_q[ch_q];

  // 32-bit product keeps the full-scale count (1.5M * 339) without overflow.
  assign dist_calc = 16'((cnt_q * 32'd339) / 32'd100000);

  // First eligible channel strictly after the previous one; channel 0 first after reset.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    sel_idx   = '0;
    sel_base  = first_q ? '0 : ({1'b0, last_q} + (CH_W+1)'(1));
    for (int k = 0; k < int'(N_CH); k++) begin
      sel_idx = sel_base + (CH_W+1)'(k);
      if (sel_idx >= N_CH_L) begin
        sel_idx = sel_idx - N_CH_L;
      end
      if (!sel_found && ch_mask[sel_idx[CH_W-1:0]]) begin
        sel_found = 1'b1;
        sel_ch    = sel_idx[CH_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q     <= StIdle;
      echo_meta_q <= '0;
      echo_sync_q <= '0;
      echo_prev_q <= 1'b0;
      cnt_q       <= '0;
      ch_q        <= '0;
      last_q      <= '0;
      first_q     <= 1'b1;
      phase_q     <= 1'b0;
      dist_new_q  <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        dist_q[i] <= '0;
      end
      trig_q      <= '0;
      op_q        <= '0;
      to_q        <= '0;
      meas_done_q <= 1'b0;
      meas_ch_q   <= '0;
    end else begin
      echo_meta_q <= echo_rx;
      echo_sync_q <= echo_meta_q;
      meas_done_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (enable && (|ch_mask)) begin
            state_q <= StSelect;
          end
        end

        StSelect: begin
          if (sel_found) begin
            ch_q    <= sel_ch;
            last_q  <= sel_ch;
            first_q <= 1'b0;
            trig_q  <= N_CH'(1) << sel_ch;
            cnt_q   <= '0;
            state_q <= StTrig;
          end else begin
            state_q <= StIdle;
          end
        end

        StTrig: begin
          if (cnt_q == TRIG_LAST) begin
            trig_q      <= '0;
            cnt_q       <= '0;
            // Treat the echo as high so a level already present must fall first.
            echo_prev_q <= 1'b1;
            state_q     <= StWaitEcho;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        StWaitEcho: begin
          echo_prev_q <= echo_cur;
          if (echo_cur && !echo_prev_q) begin
            cnt_q   <= 32'd1;
            state_q <= StMeasure;
          end else if (cnt_q == TIMEOUT_LAST) begin
            dist_q[ch_q] <= '0;
            op_q[ch_q]   <= 1'b0;
            to_q[ch_q]   <= 1'b1;
            meas_done_q  <= 1'b1;
            meas_ch_q    <= 2'(ch_q);
            cnt_q        <= '0;
            state_q      <= StGap;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        StMeasure: begin
          if (!echo_cur) begin
            phase_q <= 1'b0;
            state_q <= StCalc;
          end else if (cnt_q >= TIMEOUT_LAST) begin
            dist_q[ch_q] <= '0;
            op_q[ch_q]   <= 1'b0;
            to_q[ch_q]   <= 1'b1;
            meas_done_q  <= 1'b1;
            meas_ch_q    <= 2'(ch_q);
            cnt_q        <= '0;
            state_q      <= StGap;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        // Two cycles: register the quotient, then publish the result.
        StCalc: begin
          if (!phase_q) begin
            dist_new_q <= dist_calc;
            phase_q    <= 1'b1;
          end else begin
            dist_q[ch_q] <= dist_new_q;
            op_q[ch_q]   <= (dist_new_q != 16'd0) && (dist_new_q < OBST_TH);
            to_q[ch_q]   <= 1'b0;
            meas_done_q  <= 1'b1;
            meas_ch_q    <= 2'(ch_q);
            phase_q      <= 1'b0;
            cnt_q        <= '0;
            state_q      <= StGap;
          end
        end

        StGap: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= (enable && (|ch_mask)) ? StSelect : StIdle;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_dist
    assign distance_out[16*g +: 16] = dist_q[g];
  end

  assign trig      = trig_q;
  assign op        = op_q;
  assign timeout   = to_q;
  assign meas_done = meas_done_q;
  assign meas_ch   = meas_ch_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler with shortened timing parameters.
module tb_ultrasonic_scheduler;

  localparam int unsigned N_CH    = 3;
  localparam int unsigned TRIG    = 5;
  localparam int unsigned TMO     = 4000;
  localparam int unsigned GAP     = 50;
  localparam int unsigned OBST    = 5;

  logic              clk_50M = 1'b0;
  logic              reset;
  logic              enable;
  logic [N_CH-1:0]   ch_mask;
  logic [N_CH-1:0]   echo_rx;
  logic [N_CH-1:0]   trig;
  logic [16*N_CH-1:0] distance_out;
  logic [N_CH-1:0]   op;
  logic [N_CH-1:0]   timeout;
  logic              meas_done;
  logic [1:0]        meas_ch;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  ultrasonic_scheduler #(
    .N_CH           (N_CH),
    .TRIG_CYCLES    (TRIG),
    .TIMEOUT_CYCLES (TMO),
    .GAP_CYCLES     (GAP),
    .OBST_MM        (OBST)
  ) u_dut (
    .clk_50M      (clk_50M),
    .reset        (reset),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .echo_rx      (echo_rx),
    .trig         (trig),
    .distance_out (distance_out),
    .op           (op),
    .timeout      (timeout),
    .meas_done    (meas_done),
    .meas_ch      (meas_ch),
    .busy         (busy)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  // Trigger monitor: pulse width, one-hot and spacing between pulses.
  logic [N_CH-1:0] trig_prev = '0;
  int              hi_cnt    = 0;
  longint          cyc       = 0;
  longint          last_fall = 0;
  bit              seen_fall = 1'b0;

  always @(posedge clk_50M) begin
    #1;
    cyc++;
    if (reset) begin
      seen_fall = 1'b0;
      hi_cnt    = 0;
    end else if (trig != '0 && trig_prev == '0) begin
      check("trig_onehot", $countones(trig), 1);
      if (seen_fall) begin
        check("trig_gap", (cyc - last_fall >= GAP) ? 1 : 0, 1);
      end
      hi_cnt = 1;
    end else if (trig != '0) begin
      hi_cnt++;
    end
    if (!reset && trig == '0 && trig_prev != '0) begin
      check("trig_width", hi_cnt, TRIG);
      last_fall = cyc;
      seen_fall = 1'b1;
    end
    trig_prev = trig;
  end

  task automatic wait_trig(input int ch);
    int n;
    n = 0;
    while (trig == '0 && n < 3000) begin
      tick();
      n++;
    end
    check("trig_ch", trig, 3'b001 << ch);
    n = 0;
    while (trig != '0 && n < 100) begin
      tick();
      n++;
    end
    check("trig_fall", trig, 0);
  endtask

  task automatic run_meas(input int ch, input int hi, input int exp_dist, input bit exp_op,
                          input bit decoy);
    int n;
    wait_trig(ch);
    repeat (10) tick();
    echo_rx[ch] = 1'b1;
    if (decoy) echo_rx[1] = 1'b1;
    repeat (hi) tick();
    echo_rx = '0;
    n = 0;
    while (!meas_done && n < 50) begin
      tick();
      n++;
    end
    check("done_lat", n, 5);
    check("dist", distance_out[16*ch +: 16], exp_dist);
    check("op", op[ch], exp_op);
    check("timeout_clr", timeout[ch], 0);
    check("meas_ch", meas_ch, ch);
  endtask

  initial begin
    int n;
    reset   = 1'b1;
    enable  = 1'b0;
    ch_mask = '0;
    echo_rx = '0;
    repeat (3) tick();
    check("rst_trig", trig, 0);
    check("rst_dist", distance_out, 0);
    check("rst_op", op, 0);
    check("rst_timeout", timeout, 0);
    check("rst_done", meas_done, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // Enabled with an empty mask: stays idle.
    enable = 1'b1;
    repeat (20) tick();
    check("idle_empty_mask", busy, 0);
    ch_mask = 3'b111;

    run_meas(0, 2950, 10, 1'b0, 1'b0);
    run_meas(1, 1475, 5, 1'b0, 1'b0);
    run_meas(2, 1180, 4, 1'b1, 1'b0);
    run_meas(0, 1180, 4, 1'b1, 1'b0);

    // No echo on ch1: timeout after exactly TMO cycles of waiting.
    wait_trig(1);
    n = 0;
    while (!meas_done && n < TMO + 100) begin
      tick();
      n++;
    end
    check("to_lat", n, TMO);
    check("to_flag", timeout[1], 1);
    check("to_dist", distance_out[31:16], 0);
    check("to_op", op[1], 0);
    check("to_meas_ch", meas_ch, 1);

    run_meas(2, 294, 0, 1'b0, 1'b0);
    ch_mask = 3'b101;
    run_meas(0, 295, 1, 1'b1, 1'b1);
    run_meas(2, 2950, 10, 1'b0, 1'b1);
    run_meas(0, 1475, 5, 1'b0, 1'b1);
    check("ch1_hold_dist", distance_out[31:16], 0);
    check("ch1_hold_to", timeout[1], 1);
    check("ch2_hold_dist", distance_out[47:32], 10);

    ch_mask = 3'b111;
    run_meas(1, 1180, 4, 1'b1, 1'b0);
    run_meas(2, 1475, 5, 1'b0, 1'b0);

    // Reset in the middle of a ch0 echo measurement.
    wait_trig(0);
    repeat (10) tick();
    echo_rx[0] = 1'b1;
    repeat (100) tick();
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_trig", trig, 0);
    check("mid_rst_dist", distance_out, 0);
    check("mid_rst_op", op, 0);
    check("mid_rst_timeout", timeout, 0);
    check("mid_rst_done", meas_done, 0);
    check("mid_rst_meas_ch", meas_ch, 0);
    check("mid_rst_busy", busy, 0);
    echo_rx = '0;
    repeat (3) tick();
    reset = 1'b0;
    wait_trig(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
